iter_div: RTL and testbench

Iterative 64-bit integer divider: the inverse-operation counterpart to the pipelined multiplier, with the same start/done handshake. It sits beside `mult` in the execute stage and returns a 64-bit quotient and remainder for signed or unsigned operands. It is not pipelined. It accepts one operation at a time and shows `busy` while iterating, so issue logic can stall further divides.

---
 rtl/iter_div.sv | 169 ++++++++++++++++
 tb/tb_iter_div.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/iter_div.sv
// -----------------------------------------------------------------------------
// iter_div
// Iterative restoring divider, 64-bit, signed or unsigned. One operation at a
// time; BITS_PER_CYCLE quotient bits are resolved per clock while BUSY.
//
// Ports
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high
//   dividend   in  64   numerator, sampled when start is accepted
//   divisor    in  64   denominator, sampled when start is accepted
//   is_signed  in   1   1 = two's-complement operands
//   start      in   1   request; accepted only while busy = 0
//   quotient   out 64   registered result, valid with done
//   remainder  out 64   registered result, valid with done
//   done       out  1   one-cycle result-valid pulse
//   busy       out  1   high from the cycle after acceptance through done
// -----------------------------------------------------------------------------
module iter_div #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   input  logic        is_signed,
   input  logic        start,
   output logic [63:0] quotient,
   output logic [63:0] remainder,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   localparam int         N_CYCLES = 64 / BITS_PER_CYCLE;
   localparam logic [6:0] LAST_CNT = 7'(N_CYCLES - 1);

   if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
      $error("iter_div: BITS_PER_CYCLE must be 1, 2 or 4");
   end

   state_e      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [63:0] a_q, a_d;          // dividend magnitude, becomes the quotient
   logic [63:0] b_q, b_d;          // divisor magnitude
   logic [63:0] r_q, r_d;          // partial remainder
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [63:0] quotient_q, quotient_d;
   logic [63:0] remainder_q, remainder_d;

   logic [63:0] step_a;
   logic [63:0] step_r;
   logic [64:0] shifted;
   logic        dvd_neg, dvs_neg;

   assign dvd_neg = is_signed & dividend[63];
   assign dvs_neg = is_signed & divisor[63];

   // BITS_PER_CYCLE restoring steps chained combinationally, MSB first.
   // The 65-bit compare covers the case where the shifted-out remainder bit is
   // set, so a 2^63 divisor magnitude is handled without overflow. The
   // difference always fits in 64 bits because it is smaller than the divisor.
   always_comb begin
      step_a  = a_q;
      step_r  = r_q;
      shifted = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         shifted = {step_r, step_a[63]};
         step_a  = {step_a[62:0], 1'b0};
         if (shifted >= {1'b0, b_q}) begin
            step_r    = shifted[63:0] - b_q;
            step_a[0] = 1'b1;
         end else begin
            step_r = shifted[63:0];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         r_q         <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         r_q         <= r_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   // NOTE: every signal written in a combinational block gets a default first,
   // so no path through the case statement can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = (divisor == '0) ? S_DONE : S_BUSY;
         S_BUSY: if (cnt_q == LAST_CNT) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next-state. Results are written only on entry to DONE and are
   // otherwise held.
   always_comb begin
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      r_d         = r_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quotient_d  = '1;
                  remainder_d = dividend;
               end else begin
                  a_d    = dvd_neg ? -dividend : dividend;
                  b_d    = dvs_neg ? -divisor  : divisor;
                  r_d    = '0;
                  qneg_d = dvd_neg ^ dvs_neg;
                  rneg_d = dvd_neg;
                  cnt_d  = '0;
               end
            end
         end
         S_BUSY: begin
            a_d   = step_a;
            r_d   = step_r;
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == LAST_CNT) begin
               cnt_d       = '0;
               quotient_d  = qneg_q ? -step_a : step_a;
               remainder_d = rneg_q ? -step_r : step_r;
            end
         end
         default: ;
      endcase
   end

   // Outputs decode registered state only; no input reaches an output
   // combinationally.
   always_comb begin
      done = (state_q == S_DONE);
      busy = (state_q != S_IDLE);
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_iter_div.sv
// -----------------------------------------------------------------------------
// tb_iter_div
// Directed bench for iter_div. Two instances share operands and reset:
// u_div1 (BITS_PER_CYCLE=1) and u_div4 (BITS_PER_CYCLE=4), each with its own
// start. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_iter_div;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] dividend, divisor;
   logic        is_signed;
   logic        start1, start4;
   logic [63:0] quotient1, remainder1, quotient4, remainder4;
   logic        done1, busy1, done4, busy4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   iter_div #(.BITS_PER_CYCLE(1)) u_div1 (
      .clock(clock), .reset(reset), .dividend(dividend), .divisor(divisor),
      .is_signed(is_signed), .start(start1), .quotient(quotient1),
      .remainder(remainder1), .done(done1), .busy(busy1)
   );

   iter_div #(.BITS_PER_CYCLE(4)) u_div4 (
      .clock(clock), .reset(reset), .dividend(dividend), .divisor(divisor),
      .is_signed(is_signed), .start(start4), .quotient(quotient4),
      .remainder(remainder4), .done(done4), .busy(busy4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Issue one operation on the chosen instance and check latency, results
   // and the busy profile. The start cycle is the current falling edge.
   task automatic run_op(input string tag, input bit use4,
                         input logic [63:0] dd, input logic [63:0] dv, input bit sgn,
                         input logic [63:0] exp_q, input logic [63:0] exp_r,
                         input int exp_lat);
      int cyc;
      bit busy_all;
      dividend  = dd;
      divisor   = dv;
      is_signed = sgn;
      if (use4) start4 = 1'b1; else start1 = 1'b1;
      @(negedge clock);                     // cycle 1
      start1    = 1'b0;
      start4    = 1'b0;
      dividend  = '0;
      divisor   = '0;
      is_signed = 1'b0;
      cyc      = 1;
      busy_all = 1'b1;
      while (!(use4 ? done4 : done1) && cyc < 200) begin
         if (!(use4 ? busy4 : busy1)) busy_all = 1'b0;
         @(negedge clock);
         cyc++;
      end
      if (!(use4 ? busy4 : busy1)) busy_all = 1'b0;
      check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      check({tag, "_q"}, use4 ? quotient4 : quotient1, exp_q);
      check({tag, "_r"}, use4 ? remainder4 : remainder1, exp_r);
      check({tag, "_busy"}, 64'(busy_all), 64'd1);
      @(negedge clock);
      check({tag, "_idle"}, 64'({use4 ? busy4 : busy1, use4 ? done4 : done1}), 64'd0);
   endtask

   // Operands for the continuous-start test; accepted in cycles 0, 66, 132.
   logic [63:0] h_dd [3] = '{64'd1000, -64'sd100, 64'hFFFF_FFFF_FFFF_FFFF};
   logic [63:0] h_dv [3] = '{64'd7, 64'd7, 64'd16};
   bit          h_sg [3] = '{1'b0, 1'b1, 1'b0};
   logic [63:0] h_q  [3] = '{64'd142, -64'sd14, 64'h0FFF_FFFF_FFFF_FFFF};
   logic [63:0] h_r  [3] = '{64'd6, -64'sd2, 64'd15};

   initial begin
      int n_done;
      int exp_cyc;
      reset     = 1'b1;
      start1    = 1'b0;
      start4    = 1'b0;
      dividend  = '0;
      divisor   = '0;
      is_signed = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_q",    quotient1, 64'd0);
      check("rst_r",    remainder1, 64'd0);
      check("rst_flags", 64'({done1, busy1, done4, busy4}), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      run_op("u100_7",   1'b0, 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 65);
      run_op("s-7_2",    1'b0, -64'sd7, 64'd2, 1'b1, -64'sd3, -64'sd1, 65);
      run_op("s7_-2",    1'b0, 64'd7, -64'sd2, 1'b1, -64'sd3, 64'd1, 65);
      run_op("s_ovf",    1'b0, 64'h8000_0000_0000_0000, '1, 1'b1,
             64'h8000_0000_0000_0000, 64'd0, 65);
      run_op("u_dz",     1'b0, 64'h1234, 64'd0, 1'b0, '1, 64'h1234, 1);
      run_op("s_dz",     1'b0, 64'h1234, 64'd0, 1'b1, '1, 64'h1234, 1);
      run_op("umax_1",   1'b0, '1, 64'd1, 1'b0, '1, 64'd0, 65);
      run_op("umax_max", 1'b0, '1, '1, 1'b0, 64'd1, 64'd0, 65);
      run_op("b4_max_1",   1'b1, '1, 64'd1, 1'b0, '1, 64'd0, 17);
      run_op("b4_max_max", 1'b1, '1, '1, 1'b0, 64'd1, 64'd0, 17);
      run_op("b4_s-7_2",   1'b1, -64'sd7, 64'd2, 1'b1, -64'sd3, -64'sd1, 17);
      run_op("b4_dz",      1'b1, 64'h1234, 64'd0, 1'b1, '1, 64'h1234, 1);

      // start held high with operands changing every cycle.
      n_done  = 0;
      exp_cyc = 65;
      start1  = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (done1) begin
            check("hold_cyc", 64'(c), 64'(exp_cyc));
            if (n_done < 3) begin
               check("hold_q", quotient1, h_q[n_done]);
               check("hold_r", remainder1, h_r[n_done]);
            end
            n_done++;
            exp_cyc += 66;
         end
         if (c % 66 == 0 && c / 66 < 3) begin
            dividend  = h_dd[c / 66];
            divisor   = h_dv[c / 66];
            is_signed = h_sg[c / 66];
         end else begin
            dividend  = {$urandom, $urandom};
            divisor   = {$urandom, $urandom};
            is_signed = 1'($urandom);
         end
         @(negedge clock);
      end
      start1 = 1'b0;
      check("hold_ndone", 64'(n_done), 64'd3);
      repeat (70) @(negedge clock);

      // Reset in cycle 30 of an operation.
      dividend  = 64'd500;
      divisor   = 64'd3;
      is_signed = 1'b0;
      start1    = 1'b1;
      @(negedge clock);
      start1 = 1'b0;
      repeat (29) @(negedge clock);
      check("mid_busy", 64'(busy1), 64'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_q", quotient1, 64'd0);
      check("mid_rst_r", remainder1, 64'd0);
      check("mid_rst_flags", 64'({done1, busy1}), 64'd0);
      @(negedge clock);
      reset  = 1'b0;
      n_done = 0;
      repeat (80) begin
         @(negedge clock);
         if (done1) n_done++;
      end
      check("mid_no_done", 64'(n_done), 64'd0);
      run_op("post_rst", 1'b0, 64'd1000, 64'd10, 1'b0, 64'd100, 64'd0, 65);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
